hack_cpu: RTL and testbench

//  Hack-ISA (nand2tetris) 16-bit CPU core that executes from a synchronous ROM and reads/writes a synchronous RAM.

---
 rtl/hack_pkg.sv | 41 ++++
 rtl/hack_alu.sv | 33 +++
 rtl/hack_cpu.sv | 88 ++++++++
 tb/tb_hack_cpu.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// hack_pkg: shared definitions for the Hack CPU core.
//   - Instruction field positions (C-instruction flag, a-bit, comp/dest/jump)
//   - alu_ctrl_t: the six ALU control bits in instruction order
//   - cpu_state_t: two-phase FETCH/EXEC sequencer state
//   - jump_taken(): jump condition from the jump field and ALU flags
package hack_pkg;

   localparam int BIT_CINST = 15;
   localparam int BIT_A     = 12;
   localparam int COMP_HI   = 11;
   localparam int COMP_LO   = 6;
   localparam int DEST_HI   = 5;
   localparam int DEST_LO   = 3;
   localparam int JUMP_HI   = 2;
   localparam int JUMP_LO   = 0;
   localparam int BIT_DEST_A = 5;
   localparam int BIT_DEST_D = 4;
   localparam int BIT_DEST_M = 3;

   // Field order matches inst[11:6] so a direct cast works.
   typedef struct packed {
      logic zx;
      logic nx;
      logic zy;
      logic ny;
      logic f;
      logic no;
   } alu_ctrl_t;

   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } cpu_state_t;

   // jump = {lt, eq, gt}
   function automatic logic jump_taken(input logic [2:0] jump,
                                       input logic zr, input logic ng);
      return (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);
   endfunction

endpackage

// File: rtl/hack_alu.sv
// hack_alu: combinational Hack ALU.
//   x, y  : operands (x = D, y = A or M)
//   ctrl  : zx,nx,zy,ny,f,no
//   out   : result
//   zr    : out == 0
//   ng    : out is negative (sign bit)
module hack_alu
   import hack_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic [DATA_WIDTH-1:0] x,
   input  logic [DATA_WIDTH-1:0] y,
   input  alu_ctrl_t             ctrl,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  zr,
   output logic                  ng
);

   logic [DATA_WIDTH-1:0] x0, x1, y0, y1, o0;

   always_comb begin
      x0  = ctrl.zx ? '0 : x;
      x1  = ctrl.nx ? ~x0 : x0;
      y0  = ctrl.zy ? '0 : y;
      y1  = ctrl.ny ? ~y0 : y0;
      o0  = ctrl.f ? (x1 + y1) : (x1 & y1);
      out = ctrl.no ? ~o0 : o0;
      zr  = (out == '0);
      ng  = out[DATA_WIDTH-1];
   end

endmodule

// File: rtl/hack_cpu.sv
// hack_cpu: Hack-ISA 16-bit core, fixed two-cycle FETCH/EXEC sequence.
// Both memories are registered-read, so the ROM word for PC and the RAM word
// for A become valid during EXEC; A/D/PC commit on the edge that ends EXEC.
//   clk        : CPU clock
//   resetN     : async active-low reset
//   SW         : board switches, reserved (no effect)
//   inst       : ROM read data (valid in EXEC)
//   in_m       : RAM read data (valid in EXEC)
//   out_m      : ALU result, RAM write data
//   write_m    : RAM write enable (EXEC only)
//   data_addr  : RAM address = A[14:0]
//   inst_addr  : ROM address = PC
module hack_cpu
   import hack_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 15
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic [3:0]            SW,
   input  logic [DATA_WIDTH-1:0] inst,
   input  logic [DATA_WIDTH-1:0] in_m,
   output logic [DATA_WIDTH-1:0] out_m,
   output logic                  write_m,
   output logic [ADDR_WIDTH-1:0] data_addr,
   output logic [ADDR_WIDTH-1:0] inst_addr
);

   cpu_state_t            state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] a_reg, d_reg;

   logic                  c_instr;
   logic [DATA_WIDTH-1:0] y_op, alu_out;
   logic                  zr, ng, take;

   // Switches and the two don't-care C-instruction bits are intentionally unused.
   logic unused_bits;
   assign unused_bits = ^{SW, inst[14:13]};

   assign c_instr = inst[BIT_CINST];
   assign y_op    = inst[BIT_A] ? in_m : a_reg;

   hack_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .x    (d_reg),
      .y    (y_op),
      .ctrl (alu_ctrl_t'(inst[COMP_HI:COMP_LO])),
      .out  (alu_out),
      .zr   (zr),
      .ng   (ng)
   );

   assign take      = jump_taken(inst[JUMP_HI:JUMP_LO], zr, ng);
   assign out_m     = alu_out;
   // Decoded from the state register so an async reset drops it at once.
   assign write_m   = (state == EXEC) & c_instr & inst[BIT_DEST_M];
   // A still holds its pre-instruction value during EXEC, so a write
   // combined with dest A targets the old address.
   assign data_addr = a_reg[ADDR_WIDTH-1:0];
   assign inst_addr = pc;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state <= FETCH;
         pc    <= '0;
         a_reg <= '0;
         d_reg <= '0;
      end else begin
         case (state)
            FETCH: state <= EXEC;
            EXEC: begin
               state <= FETCH;
               if (!c_instr) begin
                  a_reg <= {1'b0, inst[DATA_WIDTH-2:0]};
                  pc    <= pc + 1'b1;
               end else begin
                  if (inst[BIT_DEST_A]) a_reg <= alu_out;
                  if (inst[BIT_DEST_D]) d_reg <= alu_out;
                  pc <= take ? a_reg[ADDR_WIDTH-1:0] : pc + 1'b1;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_hack_cpu.sv
// tb_hack_cpu: directed bench for hack_cpu with registered ROM/RAM models.
module tb_hack_cpu;

   logic        clk = 1'b0;
   logic        resetN = 1'b1;
   logic [3:0]  SW = 4'h0;
   logic [15:0] inst = 16'h0, in_m = 16'h0;
   logic [15:0] out_m;
   logic        write_m;
   logic [14:0] data_addr, inst_addr;

   logic [15:0] rom [0:32767];
   logic [15:0] ram [0:32767];
   logic        tb_we = 1'b0;
   logic [14:0] tb_wa = '0;
   logic [15:0] tb_wd = '0;

   int checks = 0;
   int errors = 0;

   hack_cpu dut (
      .clk       (clk),
      .resetN    (resetN),
      .SW        (SW),
      .inst      (inst),
      .in_m      (in_m),
      .out_m     (out_m),
      .write_m   (write_m),
      .data_addr (data_addr),
      .inst_addr (inst_addr)
   );

   always #5 clk = ~clk;

   // Registered ROM and RAM; bench preloads RAM through tb_we.
   always @(posedge clk) begin
      inst <= rom[inst_addr];
      in_m <= ram[data_addr];
      if (tb_we) ram[tb_wa] <= tb_wd;
      else if (write_m) ram[data_addr] <= out_m;
   end

   typedef struct {
      string       name;
      logic [14:0] dval;
      logic [14:0] aval;
      logic [15:0] mval;
      logic [15:0] cinst;
      logic [15:0] exp_out;
      logic        exp_wr;
      logic [14:0] exp_pc;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_rom();
      foreach (rom[i]) rom[i] = 16'h0000;
   endtask

   task automatic ram_poke(input logic [14:0] a, input logic [15:0] d);
      @(negedge clk);
      tb_we = 1'b1; tb_wa = a; tb_wd = d;
      @(posedge clk); #1;
      tb_we = 1'b0;
   endtask

   task automatic release_reset();
      @(negedge clk);
      resetN = 1'b1;
   endtask

   initial begin
      int wr_cnt;
      logic [14:0] wr_addr;
      logic [15:0] wr_data;

      //                 name       dval      aval      mval      cinst     out       wr    pc
      vecs[0] = '{"D+A;M",    15'd3,    15'd40,   16'h0,    16'hE088, 16'h002B, 1'b1, 15'd4};
      vecs[1] = '{"D-A;JLT",  15'd5,    15'd9,    16'h0,    16'hE4D4, 16'hFFFC, 1'b0, 15'd9};
      vecs[2] = '{"D&A;JEQ",  15'h00F0, 15'h000F, 16'h0,    16'hE002, 16'h0000, 1'b0, 15'h000F};
      vecs[3] = '{"D|A;JGT",  15'h0500, 15'h0033, 16'h0,    16'hE549, 16'h0533, 1'b1, 15'h0033};
      vecs[4] = '{"M-D;M",    15'h0010, 15'h0020, 16'h0100, 16'hF1C8, 16'h00F0, 1'b1, 15'd4};
      vecs[5] = '{"!D;JNE",   15'h7FFF, 15'h0100, 16'h0,    16'hE345, 16'h8000, 1'b0, 15'h0100};
      vecs[6] = '{"-1;JGE",   15'd1,    15'd2,    16'h0,    16'hEE83, 16'hFFFF, 1'b0, 15'd4};
      vecs[7] = '{"D-1;JLE",  15'd1,    15'h7FFF, 16'h0,    16'hE386, 16'h0000, 1'b0, 15'h7FFF};
      vecs[8] = '{"A+1;AM",   15'd0,    15'h0042, 16'h0,    16'hEDE8, 16'h0043, 1'b1, 15'd4};

      foreach (ram[i]) ram[i] = 16'h0000;
      #3 resetN = 1'b0;

      // ---- 1. reset, including abort mid-EXEC ----
      clear_rom();
      rom[0] = 16'hE7C8;                  // M=D+1
      ram_poke(15'd0, 16'hAAAA);
      #1;
      chk("rst_inst_addr", inst_addr, 15'd0);
      chk("rst_data_addr", data_addr, 15'd0);
      chk("rst_write_m", write_m, 1'b0);
      SW = 4'hA;
      release_reset();
      tick(1);
      chk("exec_write_m", write_m, 1'b1);
      #2 resetN = 1'b0;
      #1;
      chk("abort_write_m", write_m, 1'b0);
      chk("abort_inst_addr", inst_addr, 15'd0);
      tick(1);
      chk("abort_no_write", ram[0], 16'hAAAA);
      release_reset();
      tick(1);
      chk("pc_step0", inst_addr, 15'd0);
      tick(1);
      chk("pc_step1", inst_addr, 15'd1);
      chk("rerun_write", ram[0], 16'h0001);
      tick(2);
      chk("pc_step2", inst_addr, 15'd2);

      // ---- 2. load D ----
      resetN = 1'b0;
      clear_rom();
      rom[0] = 16'h0015; rom[1] = 16'hEC10; rom[2] = 16'hE308;   // @21 D=A M=D
      SW = 4'h5;
      release_reset();
      tick(4);
      chk("ld_data_addr", data_addr, 15'd21);
      tick(1);
      chk("ld_d_out", out_m, 16'd21);
      chk("ld_d_wr", write_m, 1'b1);

      // ---- 3. memory write: exactly one write ----
      resetN = 1'b0;
      clear_rom();
      rom[0] = 16'h0016; rom[1] = 16'hEC10; rom[2] = 16'h0064; rom[3] = 16'hE7C8;
      ram_poke(15'd100, 16'h0000);
      release_reset();
      wr_cnt = 0; wr_addr = '0; wr_data = '0;
      for (int c = 0; c < 12; c++) begin
         tick(1);
         if (write_m === 1'b1) begin
            wr_cnt++; wr_addr = data_addr; wr_data = out_m;
         end
      end
      chk("wr_count", wr_cnt, 1);
      chk("wr_addr", wr_addr, 15'd100);
      chk("wr_data", wr_data, 16'd23);
      chk("wr_ram", ram[100], 16'd23);

      // ---- 4. memory read ----
      resetN = 1'b0;
      clear_rom();
      rom[0] = 16'h0005; rom[1] = 16'hFC10; rom[2] = 16'hE308;   // @5 D=M M=D
      ram_poke(15'd5, 16'h1234);
      release_reset();
      wr_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         tick(1);
         if (write_m !== 1'b0) wr_cnt++;
      end
      chk("rd_no_write", wr_cnt, 0);
      tick(1);
      chk("rd_d", out_m, 16'h1234);

      // ---- 5. jumps ----
      resetN = 1'b0;
      clear_rom();
      rom[0] = 16'h0007; rom[1] = 16'hEA87; rom[7] = 16'hEE90; rom[8] = 16'hE301;
      release_reset();
      tick(4);
      chk("jmp_target", inst_addr, 15'd7);
      tick(3);
      chk("jgt_d", out_m, 16'hFFFF);
      chk("jgt_wr", write_m, 1'b0);
      tick(1);
      chk("jgt_not_taken", inst_addr, 15'd9);

      // ---- 6a. D+A crosses into the sign bit ----
      resetN = 1'b0;
      clear_rom();
      rom[0] = 16'h7FFF; rom[1] = 16'hEC10; rom[2] = 16'h0001;
      rom[3] = 16'hE090; rom[4] = 16'hE304;                      // D=D+A, D;JLT
      release_reset();
      tick(9);
      chk("wrap_d", out_m, 16'h8000);
      tick(1);
      chk("wrap_ng_jlt", inst_addr, 15'd1);

      // ---- 6b. PC wraps 0x7FFF -> 0 ----
      resetN = 1'b0;
      clear_rom();
      rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom[32767] = 16'h0005;
      release_reset();
      tick(4);
      chk("pc_at_top", inst_addr, 15'h7FFF);
      tick(2);
      chk("pc_wrap", inst_addr, 15'd0);
      chk("pc_wrap_a", data_addr, 15'd5);

      // ---- table: @d, D=A, @a, <C-instr> ----
      foreach (vecs[k]) begin
         resetN = 1'b0;
         clear_rom();
         rom[0] = {1'b0, vecs[k].dval};
         rom[1] = 16'hEC10;
         rom[2] = {1'b0, vecs[k].aval};
         rom[3] = vecs[k].cinst;
         SW = 4'(k);
         ram_poke(vecs[k].aval, vecs[k].mval);
         release_reset();
         tick(7);
         chk({vecs[k].name, " out"}, out_m, vecs[k].exp_out);
         chk({vecs[k].name, " wr"}, write_m, vecs[k].exp_wr);
         chk({vecs[k].name, " addr"}, data_addr, vecs[k].aval);
         tick(1);
         chk({vecs[k].name, " pc"}, inst_addr, vecs[k].exp_pc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
